// File: rtl/c17_pkg.sv
// Shared types, GAT bit positions and the C17 boolean function.
package c17_pkg;

    typedef logic [4:0] c17_vec_t;
    typedef logic [1:0] c17_res_t;

    localparam logic TAG_A = 1'b0;
    localparam logic TAG_B = 1'b1;

    localparam int G1  = 0;
    localparam int G2  = 1;
    localparam int G3  = 2;
    localparam int G6  = 3;
    localparam int G7  = 4;
    localparam int G22 = 0;
    localparam int G23 = 1;

    function automatic c17_res_t c17_eval(input c17_vec_t v);
        logic     n8;
        c17_res_t r;
        n8     = v[G3] & v[G6];
        r[G22] = (v[G2] & ~n8) | (v[G1] & v[G3]);
        r[G23] = ~n8 & (v[G2] | v[G7]);
        return r;
    endfunction

endpackage

// File: rtl/c17_core.sv
// Combinational C17 evaluation between the S1 and S2 registers.
module c17_core
    import c17_pkg::*;
(
    input  c17_vec_t vec,
    output c17_res_t res
);

    assign res = c17_eval(vec);

endmodule

// File: rtl/c17_activity_sched.sv
// Two-requester round-robin scheduler feeding a 2-stage C17 pipeline.
// Define C17_ACT_CNT_EN to build the switching-activity counters.
module c17_activity_sched
    import c17_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a_valid,
    input  c17_vec_t         a_vec,
    output logic             a_ready,
    input  logic             b_valid,
    input  c17_vec_t         b_vec,
    output logic             b_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output c17_res_t         out_res,
    output logic             out_tag,
    input  logic             clr_cnt,
    output logic [CNT_W-1:0] in_toggles,
    output logic [CNT_W-1:0] out_toggles
);

    logic     last;
    logic     s1_v;
    c17_vec_t s1_vec;
    logic     s1_tag;
    logic     s2_v;
    c17_res_t s2_res;
    logic     s2_tag;
    c17_res_t core_res;

    logic     s2_load;
    logic     s1_accept;
    logic     grant_a;
    logic     grant_b;
    logic     fire;
    logic     res_load;
    c17_vec_t sel_vec;
    logic     sel_tag;

    assign s2_load   = !s2_v || out_ready;
    assign s1_accept = !s1_v || s2_load;
    assign res_load  = s2_load && s1_v;

    // The requester that was not served last wins a conflict.
    assign grant_a = a_valid && (!b_valid || last == TAG_B);
    assign grant_b = b_valid && (!a_valid || last == TAG_A);
    assign a_ready = grant_a && s1_accept;
    assign b_ready = grant_b && s1_accept;
    assign fire    = a_ready || b_ready;
    assign sel_vec = grant_a ? a_vec : b_vec;
    assign sel_tag = grant_a ? TAG_A : TAG_B;

    c17_core u_core (
        .vec (s1_vec),
        .res (core_res)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last   <= TAG_B;
            s1_v   <= 1'b0;
            s1_vec <= '0;
            s1_tag <= TAG_A;
            s2_v   <= 1'b0;
            s2_res <= '0;
            s2_tag <= TAG_A;
        end else begin
            if (s1_accept) begin
                s1_v <= fire;
            end
            if (fire) begin
                s1_vec <= sel_vec;
                s1_tag <= sel_tag;
                last   <= sel_tag;
            end
            if (s2_load) begin
                s2_v <= s1_v;
            end
            if (res_load) begin
                s2_res <= core_res;
                s2_tag <= s1_tag;
            end
        end
    end

    assign out_valid = s2_v;
    assign out_res   = s2_res;
    assign out_tag   = s2_tag;

`ifdef C17_ACT_CNT_EN
    logic [CNT_W-1:0] in_cnt;
    logic [CNT_W-1:0] out_cnt;
    c17_vec_t         prev_vec;
    c17_res_t         prev_res;
    logic [2:0]       in_pop;
    logic [2:0]       out_pop;

    function automatic logic [CNT_W-1:0] sat_add(
        input logic [CNT_W-1:0] c,
        input logic [2:0]       d
    );
        logic [CNT_W:0] s;
        s = {1'b0, c} + (CNT_W+1)'(d);
        return s[CNT_W] ? '1 : s[CNT_W-1:0];
    endfunction

    assign in_pop  = 3'($countones(sel_vec ^ prev_vec));
    assign out_pop = 3'($countones(core_res ^ prev_res));

    // Clear beats a coincident increment; history registers survive it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            in_cnt   <= '0;
            out_cnt  <= '0;
            prev_vec <= '0;
            prev_res <= '0;
        end else begin
            if (fire) begin
                prev_vec <= sel_vec;
            end
            if (res_load) begin
                prev_res <= core_res;
            end
            if (clr_cnt) begin
                in_cnt  <= '0;
                out_cnt <= '0;
            end else begin
                if (fire) begin
                    in_cnt <= sat_add(in_cnt, in_pop);
                end
                if (res_load) begin
                    out_cnt <= sat_add(out_cnt, out_pop);
                end
            end
        end
    end

    assign in_toggles  = in_cnt;
    assign out_toggles = out_cnt;
`else
    logic unused_clr;

    assign unused_clr  = clr_cnt;
    assign in_toggles  = '0;
    assign out_toggles = '0;
`endif

endmodule

// File: tb/tb_c17_activity_sched.sv
// Directed bench for c17_activity_sched (CNT_W=4); counter expectations
// follow whether C17_ACT_CNT_EN is defined.
module tb_c17_activity_sched;

    localparam int CW = 4;
`ifdef C17_ACT_CNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    logic          clk;
    logic          rst_n;
    logic          a_valid;
    logic [4:0]    a_vec;
    logic          a_ready;
    logic          b_valid;
    logic [4:0]    b_vec;
    logic          b_ready;
    logic          out_valid;
    logic          out_ready;
    logic [1:0]    out_res;
    logic          out_tag;
    logic          clr_cnt;
    logic [CW-1:0] in_toggles;
    logic [CW-1:0] out_toggles;

    int passed = 0;
    int failed = 0;
    int total  = 0;

    c17_activity_sched #(.CNT_W(CW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .a_valid     (a_valid),
        .a_vec       (a_vec),
        .a_ready     (a_ready),
        .b_valid     (b_valid),
        .b_vec       (b_vec),
        .b_ready     (b_ready),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_res     (out_res),
        .out_tag     (out_tag),
        .clr_cnt     (clr_cnt),
        .in_toggles  (in_toggles),
        .out_toggles (out_toggles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] cexp(input int v);
        return CNT_ON ? 32'(v) : 32'd0;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        a_valid   = 1'b0;
        a_vec     = '0;
        b_valid   = 1'b0;
        b_vec     = '0;
        out_ready = 1'b1;
        clr_cnt   = 1'b0;
        step();
        step();
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_res", 32'(out_res), 0);
        chk("rst_out_tag", 32'(out_tag), 0);
        chk("rst_a_ready", 32'(a_ready), 0);
        chk("rst_b_ready", 32'(b_ready), 0);
        chk("rst_in_tog", 32'(in_toggles), 0);
        chk("rst_out_tog", 32'(out_toggles), 0);

        // A sends 00111 -> 11 two edges later
        rst_n = 1'b1;
        step();
        a_valid = 1'b1;
        a_vec   = 5'b00111;
        #1;
        chk("t1_a_ready", 32'(a_ready), 1);
        chk("t1_b_ready", 32'(b_ready), 0);
        step();
        a_valid = 1'b0;
        #1;
        chk("t1_lat_valid", 32'(out_valid), 0);
        chk("t1_in_tog", 32'(in_toggles), cexp(3));
        step();
        chk("t1_valid", 32'(out_valid), 1);
        chk("t1_res", 32'(out_res), 3);
        chk("t1_tag", 32'(out_tag), 0);
        chk("t1_out_tog", 32'(out_toggles), cexp(2));

        // A sends 01100 -> 00
        a_valid = 1'b1;
        a_vec   = 5'b01100;
        #1;
        chk("t2_a_ready", 32'(a_ready), 1);
        step();
        a_valid = 1'b0;
        step();
        chk("t2_valid", 32'(out_valid), 1);
        chk("t2_res", 32'(out_res), 0);
        chk("t2_tag", 32'(out_tag), 0);
        chk("t2_in_tog", 32'(in_toggles), cexp(6));
        chk("t2_out_tog", 32'(out_toggles), cexp(4));
        step();
        chk("t2_drained", 32'(out_valid), 0);

        // Fresh reset so last=B and A wins the first conflict
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        a_valid = 1'b1;
        a_vec   = 5'b10000;
        b_valid = 1'b1;
        b_vec   = 5'b00000;
        for (int i = 0; i < 6; i++) begin
            #1;
            chk($sformatf("t3_a_ready%0d", i), 32'(a_ready), 32'(i % 2 == 0));
            chk($sformatf("t3_b_ready%0d", i), 32'(b_ready), 32'(i % 2 == 1));
            if (i >= 2) begin
                chk($sformatf("t3_valid%0d", i), 32'(out_valid), 1);
                chk($sformatf("t3_tag%0d", i), 32'(out_tag), 32'((i - 2) % 2));
                chk($sformatf("t3_res%0d", i), 32'(out_res),
                    ((i - 2) % 2 == 0) ? 32'd2 : 32'd0);
            end
            step();
        end
        chk("t3_tail_tag_a", 32'(out_tag), 0);
        chk("t3_tail_res_a", 32'(out_res), 2);
        a_valid = 1'b0;
        b_valid = 1'b0;
        step();
        chk("t3_tail_tag_b", 32'(out_tag), 1);
        chk("t3_tail_res_b", 32'(out_res), 0);
        step();
        chk("t3_drained", 32'(out_valid), 0);
        chk("t3_in_tog", 32'(in_toggles), cexp(6));
        chk("t3_out_tog", 32'(out_toggles), cexp(6));

        // Stall with both stages full
        out_ready = 1'b0;
        a_valid   = 1'b1;
        a_vec     = 5'b00111;
        #1;
        chk("t4_a_ready", 32'(a_ready), 1);
        step();
        a_valid = 1'b0;
        b_valid = 1'b1;
        b_vec   = 5'b01100;
        #1;
        chk("t4_b_ready", 32'(b_ready), 1);
        step();
        a_valid = 1'b1;
        a_vec   = 5'b10000;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("t4_hold_valid%0d", k), 32'(out_valid), 1);
            chk($sformatf("t4_hold_res%0d", k), 32'(out_res), 3);
            chk($sformatf("t4_hold_tag%0d", k), 32'(out_tag), 0);
            chk($sformatf("t4_hold_a_rdy%0d", k), 32'(a_ready), 0);
            chk($sformatf("t4_hold_b_rdy%0d", k), 32'(b_ready), 0);
            step();
        end
        out_ready = 1'b1;
        b_valid   = 1'b0;
        #1;
        chk("t4_rel_a_ready", 32'(a_ready), 1);
        step();
        a_valid = 1'b0;
        #1;
        chk("t4_d1_valid", 32'(out_valid), 1);
        chk("t4_d1_res", 32'(out_res), 0);
        chk("t4_d1_tag", 32'(out_tag), 1);
        step();
        chk("t4_d2_valid", 32'(out_valid), 1);
        chk("t4_d2_res", 32'(out_res), 2);
        chk("t4_d2_tag", 32'(out_tag), 0);
        step();
        chk("t4_drained", 32'(out_valid), 0);
        chk("t4_in_tog", 32'(in_toggles), cexp(15));
        chk("t4_out_tog", 32'(out_toggles), cexp(11));

        // Clear, then saturate the 4-bit input counter
        clr_cnt = 1'b1;
        step();
        clr_cnt = 1'b0;
        #1;
        chk("t5_clr_in", 32'(in_toggles), 0);
        chk("t5_clr_out", 32'(out_toggles), 0);
        begin
            logic [4:0] sv [5];
            int         se [5];
            sv = '{5'b11111, 5'b00000, 5'b11111, 5'b00000, 5'b11111};
            se = '{4, 9, 14, 15, 15};
            a_valid = 1'b1;
            for (int j = 0; j < 5; j++) begin
                a_vec = sv[j];
                step();
                chk($sformatf("t5_sat%0d", j), 32'(in_toggles), cexp(se[j]));
            end
        end
        a_vec   = 5'b00000;
        clr_cnt = 1'b1;
        step();
        clr_cnt = 1'b0;
        a_valid = 1'b0;
        #1;
        chk("t5_clr_win_in", 32'(in_toggles), 0);
        chk("t5_clr_win_out", 32'(out_toggles), 0);
        step();
        chk("t5_post_in", 32'(in_toggles), 0);
        chk("t5_post_out", 32'(out_toggles), cexp(1));
        step();

        // Reset with both stages full drops the in-flight vectors
        out_ready = 1'b0;
        a_valid   = 1'b1;
        a_vec     = 5'b00111;
        step();
        a_valid = 1'b0;
        b_valid = 1'b1;
        b_vec   = 5'b01100;
        step();
        b_valid = 1'b0;
        #1;
        chk("t6_full_valid", 32'(out_valid), 1);
        rst_n = 1'b0;
        step();
        chk("t6_rst_valid", 32'(out_valid), 0);
        chk("t6_rst_res", 32'(out_res), 0);
        chk("t6_rst_in", 32'(in_toggles), 0);
        chk("t6_rst_out", 32'(out_toggles), 0);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("t6_dropped%0d", k), 32'(out_valid), 0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/c17_activity_sched.md
# c17_activity_sched

Two-requester scheduler and pipeline wrapper around the C17 benchmark logic for power-aware synthesis evaluation. It round-robin arbitrates 5-bit input vectors from two sources and applies them to a registered C17 core. Results are returned with the requester tag over a valid/ready handshake. Optional switching-activity counters accumulate input and output toggle counts for power estimation.

## Interface
- `CNT_W`, 16: width of the saturating activity counters.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: synchronous, active-low reset.
- `a_valid` / `b_valid` input 1: requester A/B offers a vector.
- `a_vec` / `b_vec` input 5: vector bits; [0]=1GAT, [1]=2GAT, [2]=3GAT, [3]=6GAT, [4]=7GAT.
- `a_ready` / `b_ready` output 1: requester vector accepted this cycle when valid&&ready.
- `out_valid` output 1: result available.
- `out_ready` input 1: consumer accepts the result.
- `out_res` output 2: [0]=22GAT, [1]=23GAT.
- `out_tag` output 1: 0=A, 1=B.
- `clr_cnt` input 1: synchronous clear of the activity counters.
- `in_toggles` output CNT_W: cumulative input-bit toggles.
- `out_toggles` output CNT_W: cumulative result-bit toggles.

## Operation
- C17 function: n8=v2&v3; r0=(v1&~n8)|(v0&v2); r1=~n8&(v1|v4).
- Pipeline:
  - S1 register holds vec, tag and s1_v.
  - S2 register holds res, tag and s2_v; it drives out_*.
- Advance rules:
  - S2 loads when !s2_v || out_ready.
  - S1 can accept when !s1_v || S2 loads.
  - No bubbles while the consumer is ready: one vector per cycle sustained.
- Arbiter:
  - Round-robin with `last` flag; reset `last`=B, so A wins the first conflict.
  - One valid requester: it is granted.
  - Both valid: the requester other than `last` is granted.
  - `last` updates only on an actual acceptance.
- Ready:
  - x_ready = grant_x && S1-can-accept.
  - Ready never depends on the requester's own valid beyond the arbitration.
  - Ready is never asserted to both requesters in one cycle.
- Stall behaviour:
  - out_valid && !out_ready holds out_res and out_tag stable.
  - S1 holds when S2 is stalled; requesters see ready=0.
- Activity accounting, when compiled in:
  - On S1 load: in_toggles += popcount(new_vec ^ prev_vec); prev_vec <= new_vec.
  - On S2 load of a valid result: out_toggles += popcount(new_res ^ prev_res); prev_res <= new_res.
  - prev_vec and prev_res reset to 0.
  - Both counters saturate at 2^CNT_W-1; no wrap.
  - clr_cnt zeroes both counters. When clr_cnt coincides with an increment, clear wins and the counter reads 0 next cycle.
  - prev_vec and prev_res are not cleared by clr_cnt.
- Reset:
  - Synchronous; clears s1_v and s2_v. Any in-flight vectors are dropped, not delivered.
  - Reset values: out_valid=0, out_res=0, out_tag=0, a_ready=0, b_ready=0, in_toggles=0, out_toggles=0, last=B.

## Timing
- Vector accepted at edge k: out_valid=1 from edge k+1 to the handshake edge.
- Latency: 2 cycles to visibility with out_ready held high.
- Throughput: 1 vector per cycle.
- Counters reflect an acceptance one edge after it.
- Ready outputs are combinational from registered state, valid inputs and out_ready. No combinational path exists from a_vec/b_vec to any output.

## Configuration
- `C17_ACT_CNT_EN` defined: activity counters, prev_vec/prev_res registers and clr_cnt logic are built.
- `C17_ACT_CNT_EN` undefined:
  - in_toggles and out_toggles are tied to 0 and clr_cnt is ignored.
  - Scheduling and pipeline behaviour is identical.

## Structure
- Shared package `c17_pkg`:
  - `c17_vec_t` (5b) and `c17_res_t` (2b).
  - `TAG_A`=0, `TAG_B`=1.
  - Bit-index constants for the GAT signals.
  - `c17_eval` function.
- Sub-module `c17_core`: purely combinational C17 evaluation, instantiated once between S1 and S2.
- Arbiter and counters are inline in `c17_activity_sched`.

## Test plan
- Reset, then A sends 5'b00111 with out_ready=1 -> out_res=2'b11, tag 0, two cycles later; in_toggles=3, out_toggles=2.
- Then A sends 5'b01100 -> out_res=2'b00; in_toggles=6, out_toggles=4.
- A and B both valid continuously with vectors 5'b10000 and 5'b00000 -> grants alternate A,B,A,B; results 2'b10 (tag 0) and 2'b00 (tag 1) alternate, one per cycle.
- out_ready held 0 for 3 cycles with both stages full -> out_res and out_tag stable, a_ready=b_ready=0; on release, results drain in order with no loss or duplication.
- Counter saturation: with CNT_W=4, alternate 5'b00000 and 5'b11111 -> in_toggles sticks at 15. clr_cnt asserted on an incrementing cycle -> 0 next cycle.
- rst_n low for one cycle with both stages full -> out_valid=0 next cycle and both counters 0; that vector is never delivered. Without C17_ACT_CNT_EN, both counters read 0 throughout.
